// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
//   Pop-side interface of the UART receiver FIFO.
//   master : the receiver (drives data/status, samples rx_ready)
//   slave  : the consumer (samples data/status, drives rx_ready)
//   Signals:
//     rx_data    [7:0]   FIFO head byte, meaningful while rx_valid=1
//     rx_valid           FIFO not empty
//     rx_ready           consumer pop request
//     frame_err          1-cycle pulse, byte discarded on bad stop bit
//     overrun            1-cycle pulse, good byte dropped on full FIFO
//     fifo_count         number of stored bytes
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             frame_err;
    logic             overrun;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, fifo_count,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, fifo_count,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   8N1 UART receiver with 16x oversampling, start/stop validation and a
//   small first-word fall-through FIFO popped through a valid/ready handshake.
//   Ports:
//     clk    in   system clock, rising edge
//     rst_n  in   asynchronous active-low reset (released synchronously)
//     RsRx   in   serial line, idle high, asynchronous to clk
//     rx_if  master modport of uart_rx_fifo_if (data, valid, ready,
//            frame_err, overrun, fifo_count)
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int DEPTH    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           RsRx,
    uart_rx_fifo_if.master rx_if
);
    localparam int DIV   = CLK_FREQ / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Reset synchroniser: assertion is immediate, release is aligned to clk.
    logic rst_meta_q;
    logic rst_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // Line synchroniser; resets to the idle (high) level so reset never
    // looks like a start bit.
    logic sync1_q;
    logic sync2_q;
    logic rx_s;

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= RsRx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // Free-running 16x baud tick.
    logic [DIV_W-1:0] div_cnt_q;
    logic             tick;

    assign tick = (div_cnt_q == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            div_cnt_q <= '0;
        end else if (tick) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
        end
    end

    state_t     state_q;
    logic [3:0] os_cnt_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shreg_q;
    logic       frame_err_q;
    logic       overrun_q;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic stop_sample;
    logic good_byte;
    logic full;
    logic pop;
    logic push;
    logic frame_err_d;
    logic overrun_d;

    // Fullness is judged on the pre-pop count; a same-cycle pop frees the
    // slot the new byte lands in, so the push is still accepted.
    always_comb begin
        stop_sample = (state_q == S_STOP) && tick && (os_cnt_q == 4'd15);
        good_byte   = stop_sample && rx_s;
        full        = (count_q == CNT_W'(DEPTH));
        pop         = rx_if.rx_ready && (count_q != '0);
        push        = good_byte && (!full || pop);
        overrun_d   = good_byte && full && !pop;
        frame_err_d = stop_sample && !rx_s;
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q     <= S_IDLE;
            os_cnt_q    <= 4'd0;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'd0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_q  <= S_START;
                        os_cnt_q <= 4'd0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (os_cnt_q == 4'd7) begin
                            os_cnt_q <= 4'd0;
                            if (!rx_s) begin
                                state_q   <= S_DATA;
                                bit_cnt_q <= 3'd0;
                            end else begin
                                // Too short to be a start bit: silently ignore.
                                state_q <= S_IDLE;
                            end
                        end else begin
                            os_cnt_q <= os_cnt_q + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        // 15 -> 0 wrap puts the next sample one bit later.
                        os_cnt_q <= os_cnt_q + 4'd1;
                        if (os_cnt_q == 4'd15) begin
                            shreg_q   <= {rx_s, shreg_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q  <= S_STOP;
                                os_cnt_q <= 4'd0;
                            end
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (os_cnt_q == 4'd15) begin
                            // Return to IDLE mid stop bit so a start bit
                            // straight after it is caught.
                            state_q  <= S_IDLE;
                            os_cnt_q <= 4'd0;
                        end else begin
                            os_cnt_q <= os_cnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    os_cnt_q <= 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is reset so the head byte reads 0 after reset.
    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= shreg_q;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign rx_if.rx_data    = mem_q[rd_ptr_q];
    assign rx_if.rx_valid   = (count_q != '0);
    assign rx_if.fifo_count = count_q;
    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.overrun    = overrun_q;

endmodule
